// File: rtl/keypad_matrix_scan_pkg.sv
// Shared constants for the key matrix scanner: matrix geometry common with the
// LED row-scan display driver, and the scan FSM state encoding.
package keypad_matrix_scan_pkg;

  // Matrix is SIZE x SIZE; ADDRESS = clog2(SIZE) bits select a row.
  localparam int unsigned SIZE    = 8;
  localparam int unsigned ADDRESS = 3;

  // Scan FSM: drive a row and let it settle, sample its columns, then close the frame.
  typedef enum logic [1:0] {
    StDrive   = 2'd0,
    StSample  = 2'd1,
    StCompare = 2'd2
  } scan_state_e;

endpackage

// File: rtl/keypad_matrix_scan_col_sync.sv
// SIZE-wide two-flop synchronizer for the asynchronous key column lines.
module keypad_matrix_scan_col_sync #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] meta_q;
  logic [SIZE-1:0] sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// Key matrix row scanner: strobes one row at a time, samples the synchronized
// column lines into a raw frame and debounces whole frames into keys.
// Key bit (r*SIZE + c) is the key at row r, column c (display frame layout).
module keypad_matrix_scan
  import keypad_matrix_scan_pkg::*;
#(
  parameter int unsigned SIZE       = keypad_matrix_scan_pkg::SIZE,
  parameter int unsigned ADDRESS    = keypad_matrix_scan_pkg::ADDRESS,
  parameter int unsigned SETTLE     = 4,  // >= 3 so the 2-flop sync has caught up
  parameter int unsigned DEB_FRAMES = 3   // >= 1 identical frames before keys update
) (
  input  logic                 osc_clk,
  input  logic                 rst_n,
  input  logic                 scan_en,
  input  logic [SIZE-1:0]      col_in,
  output logic [SIZE-1:0]      row,
  output logic [SIZE*SIZE-1:0] keys,
  output logic [SIZE*SIZE-1:0] press,
  // "release" is a reserved word in SystemVerilog, hence key_release.
  output logic [SIZE*SIZE-1:0] key_release,
  output logic                 keys_valid,
  output logic                 frame_done
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned StW  = $clog2(DEB_FRAMES) + 1;
  localparam logic [CntW-1:0]    CntLast = CntW'(SETTLE - 1);
  localparam logic [ADDRESS-1:0] IdxLast = ADDRESS'(SIZE - 1);
  localparam logic [StW-1:0]     StMax   = StW'(DEB_FRAMES - 1);
  // stable count seen just before the DEB_FRAMES-th identical frame
  localparam logic [StW-1:0]     StHit   = StW'((DEB_FRAMES >= 2) ? DEB_FRAMES - 2 : 0);

  scan_state_e            state_q, state_d;
  logic [ADDRESS-1:0]     idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   active_q;
  logic [SIZE*SIZE-1:0]   raw_q, raw_d;
  logic [SIZE*SIZE-1:0]   last_raw_q, last_raw_d;
  logic [StW-1:0]         stable_q, stable_d;
  logic [SIZE*SIZE-1:0]   keys_q, keys_d;
  logic [SIZE*SIZE-1:0]   press_q, press_d;
  logic [SIZE*SIZE-1:0]   rel_q, rel_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic [SIZE-1:0]        col_sync;
  logic                   same_frame;
  logic                   deb_hit;

  keypad_matrix_scan_col_sync #(
    .SIZE (SIZE)
  ) u_col_sync (
    .clk   (osc_clk),
    .rst_n (rst_n),
    .d     (col_in),
    .q     (col_sync)
  );

  assign same_frame = (raw_q == last_raw_q);
  assign deb_hit    = (DEB_FRAMES == 1) || (same_frame && (stable_q == StHit));

  // Next-state: scan sequencing, raw frame capture and frame-level debounce.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    raw_d      = raw_q;
    last_raw_d = last_raw_q;
    stable_d   = stable_q;
    keys_d     = keys_q;
    press_d    = press_q;
    rel_d      = rel_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;

    if (!scan_en) begin
      // Abandon the partial frame; the next enable starts a fresh debounce run.
      state_d  = StDrive;
      idx_d    = '0;
      cnt_d    = '0;
      raw_d    = '0;
      stable_d = '0;
    end else if (active_q) begin
      unique case (state_q)
        StDrive: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StSample;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSample: begin
          raw_d[idx_q*SIZE +: SIZE] = col_sync;
          if (idx_q == IdxLast) begin
            state_d = StCompare;
          end else begin
            idx_d   = idx_q + ADDRESS'(1);
            state_d = StDrive;
          end
        end
        StCompare: begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = StDrive;
          if (!same_frame) begin
            last_raw_d = raw_q;
            stable_d   = '0;
          end else if (stable_q != StMax) begin
            stable_d = stable_q + StW'(1);
          end
          if (deb_hit && (raw_q != keys_q)) begin
            keys_d  = raw_q;
            press_d = raw_q & ~keys_q;
            rel_d   = ~raw_q & keys_q;
            valid_d = 1'b1;
          end
        end
        default: state_d = StDrive;
      endcase
    end
  end

  // State registers; active_q delays scan start by one cycle so row drops the cycle after disable.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StDrive;
      idx_q      <= '0;
      cnt_q      <= '0;
      active_q   <= 1'b0;
      raw_q      <= '0;
      last_raw_q <= '0;
      stable_q   <= '0;
      keys_q     <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      active_q   <= scan_en;
      raw_q      <= raw_d;
      last_raw_q <= last_raw_d;
      stable_q   <= stable_d;
      keys_q     <= keys_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // Row strobe: one-hot during drive/sample, released in compare and while idle.
  always_comb begin
    row = '0;
    if (active_q && (state_q != StCompare)) begin
      row[idx_q] = 1'b1;
    end
  end

  assign keys        = keys_q;
  assign press       = press_q;
  assign key_release = rel_q;
  assign keys_valid  = valid_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Self-checking bench for keypad_matrix_scan: a virtual key matrix drives col_in from
// row, and a frame-level debounce model predicts keys/press/release/keys_valid.
module tb_keypad_matrix_scan;

  localparam int N     = 8;
  localparam int DEB   = 3;
  localparam int FRAME = 41;

  logic           osc_clk = 1'b0;
  logic           rst_n   = 1'b0;
  logic           scan_en = 1'b0;
  logic [N-1:0]   col_in;
  logic [N-1:0]   row;
  logic [N*N-1:0] keys, press, key_release;
  logic           keys_valid, frame_done;

  logic [N*N-1:0] pressed = '0;  // virtual key matrix state

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame-level reference: run = count of consecutive identical frames (capped at DEB).
  logic [N*N-1:0] m_prev, m_keys, m_press, m_rel;
  int             m_run;
  bit             m_valid;

  keypad_matrix_scan #(
    .SIZE       (N),
    .ADDRESS    (3),
    .SETTLE     (4),
    .DEB_FRAMES (DEB)
  ) dut (
    .osc_clk     (osc_clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .col_in      (col_in),
    .row         (row),
    .keys        (keys),
    .press       (press),
    .key_release (key_release),
    .keys_valid  (keys_valid),
    .frame_done  (frame_done)
  );

  always #5 osc_clk = ~osc_clk;

  // A pressed key shorts its row strobe onto its column line.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < N; r++) begin
      if (row[r]) col_in = col_in | pressed[r*N +: N];
    end
  end

  task automatic step();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_run   = 1;
    m_keys  = '0;
    m_press = '0;
    m_rel   = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_frame(input logic [N*N-1:0] f);
    if (f == m_prev) begin
      if (m_run < DEB) m_run++;
    end else begin
      m_prev = f;
      m_run  = 1;
    end
    m_valid = (m_run == DEB) && (f != m_keys);
    if (m_valid) begin
      m_press = f & ~m_keys;
      m_rel   = ~f & m_keys;
      m_keys  = f;
    end
  endtask

  // Advance to the next frame_done (bounded), noting multi-hot rows and stray keys_valid.
  task automatic wait_frame(output bit got, output int cycles, output int stray);
    got   = 1'b0;
    stray = 0;
    for (cycles = 1; cycles <= 100; cycles++) begin
      step();
      if ($countones(row) > 1) stray++;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
      if (keys_valid) stray++;
    end
  endtask

  // Hold the matrix at f for n frames, checking the outputs after each frame.
  task automatic drive_frames(input string name, input logic [N*N-1:0] f, input int n);
    bit got;
    int cyc, stray;
    for (int i = 0; i < n; i++) begin
      pressed = f;
      wait_frame(got, cyc, stray);
      n_cmp++;
      if (got !== 1'b1) begin
        n_fail++;
        $display("FAIL %s[%0d] frame_done: none within %0d cycles, want a pulse", name, i, cyc);
        return;
      end
      model_frame(f);
      n_cmp++;
      if (keys !== m_keys) begin
        n_fail++;
        $display("FAIL %s[%0d] keys: got %h want %h", name, i, keys, m_keys);
      end
      n_cmp++;
      if (press !== m_press) begin
        n_fail++;
        $display("FAIL %s[%0d] press: got %h want %h", name, i, press, m_press);
      end
      n_cmp++;
      if (key_release !== m_rel) begin
        n_fail++;
        $display("FAIL %s[%0d] release: got %h want %h", name, i, key_release, m_rel);
      end
      n_cmp++;
      if (keys_valid !== m_valid) begin
        n_fail++;
        $display("FAIL %s[%0d] keys_valid: got %b want %b", name, i, keys_valid, m_valid);
      end
      n_cmp++;
      if (stray !== 0) begin
        n_fail++;
        $display("FAIL %s[%0d] stray pulse/multi-hot row: got %0d want 0", name, i, stray);
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    scan_en = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (row !== '0) begin n_fail++; $display("FAIL reset row: got %h want 0", row); end
    n_cmp++;
    if (keys !== '0 || press !== '0 || key_release !== '0) begin
      n_fail++;
      $display("FAIL reset keys/press/release: got %h/%h/%h want 0", keys, press, key_release);
    end
    n_cmp++;
    if (keys_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pulses: got %b%b want 00", keys_valid, frame_done);
    end
    model_reset();
  endtask

  task automatic test_row_sequence();
    logic [N-1:0] exp_row;
    bit got;
    int cyc, stray;
    scan_en = 1'b0;
    pressed = '0;
    step();
    rst_n = 1'b1;
    step();
    scan_en = 1'b1;
    for (int k = 0; k <= FRAME - 1; k++) begin
      step();
      exp_row = '0;
      if (k < N * 5) exp_row[k / 5] = 1'b1;
      n_cmp++;
      if (row !== exp_row) begin
        n_fail++;
        $display("FAIL rowseq row @%0d: got %h want %h", k, row, exp_row);
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rowseq early frame_done @%0d: got 1 want 0", k);
      end
    end
    step();
    n_cmp++;
    if (frame_done !== 1'b1 || row !== 8'h01) begin
      n_fail++;
      $display("FAIL rowseq frame end: got done=%b row=%h want 1/01", frame_done, row);
    end
    model_frame('0);
    wait_frame(got, cyc, stray);
    n_cmp++;
    if (got !== 1'b1 || cyc !== FRAME) begin
      n_fail++;
      $display("FAIL rowseq period: got %0d cycles (seen=%b) want %0d", cyc, got, FRAME);
    end
    model_frame('0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 3; i++) begin
      drive_frames("bounce_on", 64'h1 << 21, 1);
      drive_frames("bounce_off", '0, 1);
    end
  endtask

  task automatic test_press_release();
    drive_frames("press21", 64'h1 << 21, 5);
    drive_frames("release21", '0, 4);
  endtask

  task automatic test_simultaneous();
    drive_frames("press0_63", (64'h1 << 63) | 64'h1, 4);
    drive_frames("swap0_9", (64'h1 << 63) | (64'h1 << 9), 4);
  endtask

  task automatic test_scan_disable();
    int guard;
    int bad;
    guard = 0;
    while (row !== 8'h20 && guard < 60) begin
      step();
      guard++;
    end
    n_cmp++;
    if (row !== 8'h20) begin
      n_fail++;
      $display("FAIL scan_en reach row5: got %h want 20", row);
    end
    scan_en = 1'b0;
    step();
    n_cmp++;
    if (row !== '0) begin n_fail++; $display("FAIL scan_en off row: got %h want 0", row); end
    n_cmp++;
    if (keys !== m_keys) begin
      n_fail++;
      $display("FAIL scan_en off keys held: got %h want %h", keys, m_keys);
    end
    bad = 0;
    pressed = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (row !== '0 || frame_done !== 1'b0 || keys_valid !== 1'b0 || keys !== m_keys) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL scan_en idle activity: got %0d bad cycles want 0", bad);
    end
    m_run   = 1;  // debounce run restarts against the last complete frame
    scan_en = 1'b1;
    step();
    n_cmp++;
    if (row !== 8'h01) begin n_fail++; $display("FAIL scan_en on row: got %h want 01", row); end
    drive_frames("restart", '0, 4);
  endtask

  task automatic test_reset_mid();
    drive_frames("pre_reset", 64'h1 << 21, 3);
    repeat (12) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (row !== '0 || keys !== '0 || press !== '0 || key_release !== '0) begin
      n_fail++;
      $display("FAIL midreset clear: got row=%h keys=%h press=%h rel=%h want 0",
               row, keys, press, key_release);
    end
    n_cmp++;
    if (keys_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset pulses: got %b%b want 00", keys_valid, frame_done);
    end
    step();
    rst_n = 1'b1;
    model_reset();
    drive_frames("post_reset", 64'h1 << 21, 3);
  endtask

  task automatic test_random();
    logic [N*N-1:0] pool[4];
    logic [N*N-1:0] f;
    for (int i = 0; i < 4; i++) begin
      pool[i] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    end
    f = pool[0];
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 99) >= 60) f = pool[$urandom_range(0, 3)];
      drive_frames("random", f, 1);
    end
  endtask

  initial begin
    test_reset();
    test_row_sequence();
    test_bounce();
    test_press_release();
    test_simultaneous();
    test_scan_disable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
